// File: rtl/conv_kernel_stream.sv
// Streaming KxK-window convolution: one sample per accepted cycle through a single MAC,
// then shift-normalise, optional round-half-up, and saturate to DATA_W with a flag.
module conv_kernel_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 4,
  parameter int TAPS   = 9,
  parameter int SHIFT  = 4,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] d,
  input  logic              clr,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [DATA_W-1:0] r,
  output logic              ready,
  output logic              sat
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic [ACC_W:0]   RND_ADD  = (ROUND != 0) ? ((ACC_W+1)'(1) << (SHIFT - 1)) : {(ACC_W+1){1'b0}};

  function automatic logic [COEF_W-1:0] f_default_coef(input int idx);
    logic [COEF_W-1:0] v;
    v = COEF_W'(1);
    if (TAPS == 9) begin
      case (idx)
        1, 3, 5, 7: v = COEF_W'(2);
        4:          v = COEF_W'(4);
        default:    v = COEF_W'(1);
      endcase
    end else begin
      v = COEF_W'(1);
    end
    return v;
  endfunction

  logic [COEF_W-1:0] r_coef [TAPS];
  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;

  logic [COEF_W-1:0] w_coef_sel;
  logic [ACC_W-1:0]  w_prod;
  logic [ACC_W-1:0]  w_acc_next;
  logic [ACC_W:0]    w_rnd;
  logic [ACC_W:0]    w_s;
  logic              w_ovf;
  logic              w_addr_ok;
  logic              w_first;
  logic              w_last;

  assign w_first    = (r_cnt == {CNT_W{1'b0}});
  assign w_last     = (r_cnt == LAST_TAP);
  assign w_coef_sel = r_coef[r_cnt];
  assign w_prod     = ACC_W'(d) * ACC_W'(w_coef_sel);
  assign w_acc_next = w_first ? w_prod : (r_acc + w_prod);
  // One extra bit so the rounding increment can never wrap the sum.
  assign w_rnd      = {1'b0, w_acc_next} + RND_ADD;
  assign w_s        = w_rnd >> SHIFT;
  assign w_ovf      = |w_s[ACC_W:DATA_W];
  assign w_addr_ok  = (32'(coef_addr) < 32'(TAPS));

  // Coefficient file; an accept on the same edge still sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= f_default_coef(i);
      end
    end else if (coef_we && w_addr_ok) begin
      r_coef[coef_addr] <= coef_data;
    end else begin
      r_coef <= r_coef;
    end
  end

  // Tap counter, accumulator and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_acc <= {ACC_W{1'b0}};
      r     <= {DATA_W{1'b0}};
      ready <= 1'b0;
      sat   <= 1'b0;
    end else if (clr) begin
      r_cnt <= {CNT_W{1'b0}};
      r_acc <= {ACC_W{1'b0}};
      ready <= 1'b0;
    end else if (start) begin
      r_acc <= w_acc_next;
      if (w_last) begin
        r_cnt <= {CNT_W{1'b0}};
        r     <= w_ovf ? {DATA_W{1'b1}} : w_s[DATA_W-1:0];
        sat   <= w_ovf;
        ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        ready <= 1'b0;
      end
    end else begin
      ready <= 1'b0;
    end
  end

endmodule
